// File: rtl/ppu_sprite_evaluator.sv
// Per-scanline sprite evaluation: clears secondary OAM, then copies every primary OAM
// sprite whose Y range covers the target scanline, flagging overflow past the slot limit.
module ppu_sprite_evaluator #(
   parameter int unsigned OAM_ENTRIES      = 64,
   parameter int unsigned SPRITES_PER_LINE = 8,
   localparam int unsigned OAW = $clog2(OAM_ENTRIES * 4),
   localparam int unsigned SAW = $clog2(SPRITES_PER_LINE * 4),
   localparam int unsigned CW  = $clog2(SPRITES_PER_LINE + 1)
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   input  logic           i_start,
   input  logic [8:0]     i_scanline,
   input  logic           i_sprite_h16,
   output logic [OAW-1:0] o_oam_addr,
   input  logic [7:0]     i_oam_data,
   output logic           o_sec_we,
   output logic [SAW-1:0] o_sec_addr,
   output logic [7:0]     o_sec_data,
   output logic           o_busy,
   output logic           o_done,
   output logic [CW-1:0]  o_sprite_count,
   output logic           o_overflow,
   output logic           o_sprite0_hit
);

   localparam int unsigned NW = $clog2(OAM_ENTRIES);

   typedef enum logic [2:0] {
      StIdle, StClear, StFetchY, StCheckY, StFetchB, StStoreB, StDone
   } state_e;

   state_e          state_q, state_d;
   logic [8:0]      scanline_q, scanline_d;
   logic            h16_q, h16_d;
   logic [NW-1:0]   n_q, n_d;
   logic [SAW-1:0]  k_q, k_d;
   logic [1:0]      b_q, b_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            sprite0_q, sprite0_d;

   logic [8:0]      y_ext;
   logic [8:0]      y_diff;
   logic            in_range;
   logic            last_n;
   logic            slots_full;

   // 9-bit unsigned compare: Y=0xFF can never wrap into range of a visible line.
   assign y_ext      = {1'b0, i_oam_data};
   assign y_diff     = scanline_q - y_ext;
   assign in_range   = (scanline_q >= y_ext) && (y_diff < (h16_q ? 9'd16 : 9'd8));
   assign last_n     = (n_q == NW'(OAM_ENTRIES - 1));
   assign slots_full = (count_q == CW'(SPRITES_PER_LINE));

   always_comb begin
      state_d    = state_q;
      scanline_d = scanline_q;
      h16_d      = h16_q;
      n_d        = n_q;
      k_d        = k_q;
      b_d        = b_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      sprite0_d  = sprite0_q;
      o_oam_addr = '0;
      o_sec_we   = 1'b0;
      o_sec_addr = '0;
      o_sec_data = 8'h00;
      o_done     = 1'b0;

      case (state_q)
         StIdle: ;
         StClear: begin
            o_sec_we   = 1'b1;
            o_sec_addr = k_q;
            o_sec_data = 8'hFF;
            k_d        = k_q + SAW'(1);
            if (k_q == SAW'(SPRITES_PER_LINE * 4 - 1)) state_d = StFetchY;
         end
         StFetchY: begin
            o_oam_addr = {n_q, 2'b00};
            state_d    = StCheckY;
         end
         StCheckY: begin
            if (!in_range) begin
               if (last_n) begin
                  state_d = StDone;
               end else begin
                  n_d     = n_q + NW'(1);
                  state_d = StFetchY;
               end
            end else if (!slots_full) begin
               o_sec_we   = 1'b1;
               o_sec_addr = SAW'({count_q, 2'b00});
               o_sec_data = i_oam_data;
               if (n_q == '0) sprite0_d = 1'b1;
               b_d        = 2'd1;
               state_d    = StFetchB;
            end else begin
               overflow_d = 1'b1;
               state_d    = StDone;
            end
         end
         StFetchB: begin
            o_oam_addr = {n_q, b_q};
            state_d    = StStoreB;
         end
         StStoreB: begin
            o_sec_we   = 1'b1;
            o_sec_addr = SAW'({count_q, b_q});
            o_sec_data = i_oam_data;
            if (b_q != 2'd3) begin
               b_d     = b_q + 2'd1;
               state_d = StFetchB;
            end else begin
               count_d = count_q + CW'(1);
               if (last_n) begin
                  state_d = StDone;
               end else begin
                  n_d     = n_q + NW'(1);
                  state_d = StFetchY;
               end
            end
         end
         StDone: begin
            o_done  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A start pulse in any state aborts the current pass and begins a fresh one.
      if (i_start) begin
         state_d    = StClear;
         scanline_d = i_scanline;
         h16_d      = i_sprite_h16;
         n_d        = '0;
         k_d        = '0;
         b_d        = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         sprite0_d  = 1'b0;
      end
   end

   always_ff @(negedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= StIdle;
         scanline_q <= '0;
         h16_q      <= 1'b0;
         n_q        <= '0;
         k_q        <= '0;
         b_q        <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         sprite0_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         scanline_q <= scanline_d;
         h16_q      <= h16_d;
         n_q        <= n_d;
         k_q        <= k_d;
         b_q        <= b_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         sprite0_q  <= sprite0_d;
      end
   end

   assign o_busy         = (state_q != StIdle);
   assign o_sprite_count = count_q;
   assign o_overflow     = overflow_q;
   assign o_sprite0_hit  = sprite0_q;

endmodule

// File: tb/tb_ppu_sprite_evaluator.sv
// Directed bench for ppu_sprite_evaluator: a per-pass trace model built from the
// sprite-in-range rules is compared against the DUT on every cycle of each pass.
module tb_ppu_sprite_evaluator;

   localparam int E = 64;
   localparam int S = 8;

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic       i_start;
   logic [8:0] i_scanline;
   logic       i_sprite_h16;
   logic [7:0] o_oam_addr;
   logic [7:0] i_oam_data;
   logic       o_sec_we;
   logic [4:0] o_sec_addr;
   logic [7:0] o_sec_data;
   logic       o_busy;
   logic       o_done;
   logic [3:0] o_sprite_count;
   logic       o_overflow;
   logic       o_sprite0_hit;

   ppu_sprite_evaluator #(
      .OAM_ENTRIES      (E),
      .SPRITES_PER_LINE (S)
   ) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_start        (i_start),
      .i_scanline     (i_scanline),
      .i_sprite_h16   (i_sprite_h16),
      .o_oam_addr     (o_oam_addr),
      .i_oam_data     (i_oam_data),
      .o_sec_we       (o_sec_we),
      .o_sec_addr     (o_sec_addr),
      .o_sec_data     (o_sec_data),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_sprite_count (o_sprite_count),
      .o_overflow     (o_overflow),
      .o_sprite0_hit  (o_sprite0_hit)
   );

   always #5 i_clk = ~i_clk;

   // Primary OAM: registered read, data valid the cycle after the address.
   logic [7:0] oam [E*4];
   always @(negedge i_clk) i_oam_data <= oam[o_oam_addr];

   // Mirror of everything the DUT writes into secondary OAM.
   logic [7:0] sec_mirror [S*4];
   int wr_count = 0;
   always @(negedge i_clk) begin
      if (o_sec_we) begin
         sec_mirror[o_sec_addr] <= o_sec_data;
         wr_count <= wr_count + 1;
      end
   end

   typedef struct {
      bit we;
      int addr;
      int data;
      bit oav;
      int oa;
      bit done;
   } cyc_t;

   cyc_t exp_q[$];
   int   exp_sec [S*4];
   int   exp_cnt;
   bit   exp_ovf;
   bit   exp_s0;

   int n_vec = 0;
   int n_err = 0;
   int done_at;
   int done_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input bit we, input int addr, input int data, input bit oav,
                       input int oa, input bit done);
      cyc_t c;
      c.we = we; c.addr = addr; c.data = data; c.oav = oav; c.oa = oa; c.done = done;
      exp_q.push_back(c);
      if (we) exp_sec[addr] = data;
   endtask

   // Expected cycle trace of one pass, derived from the in-range rule and cycle costs.
   task automatic build_model(input int sl, input bit h16);
      int y;
      bit stop;
      exp_q.delete();
      exp_cnt = 0; exp_ovf = 0; exp_s0 = 0; stop = 0;
      for (int k = 0; k < S*4; k++) push(1, k, 255, 0, 0, 0);
      for (int n = 0; n < E && !stop; n++) begin
         y = oam[4*n];
         push(0, 0, 0, 1, 4*n, 0);
         if (!(sl >= y && (sl - y) < (h16 ? 16 : 8))) begin
            push(0, 0, 0, 0, 0, 0);
         end else if (exp_cnt == S) begin
            push(0, 0, 0, 0, 0, 0);
            exp_ovf = 1;
            stop = 1;
         end else begin
            push(1, exp_cnt*4, y, 0, 0, 0);
            if (n == 0) exp_s0 = 1;
            for (int b = 1; b < 4; b++) begin
               push(0, 0, 0, 1, 4*n + b, 0);
               push(1, exp_cnt*4 + b, oam[4*n + b], 0, 0, 0);
            end
            exp_cnt++;
         end
      end
      push(0, 0, 0, 0, 0, 1);
   endtask

   task automatic check_cycle(input int c);
      cyc_t e;
      if (c >= exp_q.size()) begin
         chk($sformatf("c%0d beyond model trace", c), 1, 0);
         return;
      end
      e = exp_q[c];
      if (o_done) begin
         done_at = c;
         done_seen++;
      end
      chk($sformatf("c%0d busy", c), o_busy, 1);
      chk($sformatf("c%0d done", c), o_done, e.done);
      chk($sformatf("c%0d sec_we", c), o_sec_we, e.we);
      if (e.we) begin
         chk($sformatf("c%0d sec_addr", c), o_sec_addr, e.addr);
         chk($sformatf("c%0d sec_data", c), o_sec_data, e.data);
      end
      if (e.oav) chk($sformatf("c%0d oam_addr", c), o_oam_addr, e.oa);
   endtask

   task automatic run_cycles(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         check_cycle(c);
         @(posedge i_clk);
      end
   endtask

   // Called just after a posedge; returns at the posedge of pass cycle 0.
   task automatic start_pass(input int sl, input bit h16);
      build_model(sl, h16);
      done_at      = -1;
      i_start      = 1'b1;
      i_scanline   = 9'(sl);
      i_sprite_h16 = h16;
      @(posedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic finish_check(input string tag);
      chk({tag, " idle busy"}, o_busy, 0);
      chk({tag, " idle done"}, o_done, 0);
      chk({tag, " count"}, o_sprite_count, exp_cnt);
      chk({tag, " overflow"}, o_overflow, exp_ovf);
      chk({tag, " sprite0"}, o_sprite0_hit, exp_s0);
      for (int k = 0; k < S*4; k++)
         chk($sformatf("%s sec[%0d]", tag, k), sec_mirror[k], exp_sec[k]);
   endtask

   task automatic run_full(input string tag, input int sl, input bit h16);
      start_pass(sl, h16);
      run_cycles(exp_q.size());
      finish_check(tag);
   endtask

   task automatic oam_blank();
      for (int i = 0; i < E*4; i++) oam[i] = 8'hFF;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      i_reset_n = 1'b0; i_start = 1'b0; i_scanline = '0; i_sprite_h16 = 1'b0;
      oam_blank();
      repeat (3) @(posedge i_clk);
      chk("reset busy", o_busy, 0);
      chk("reset done", o_done, 0);
      chk("reset sec_we", o_sec_we, 0);
      chk("reset sec_addr", o_sec_addr, 0);
      chk("reset sec_data", o_sec_data, 0);
      chk("reset oam_addr", o_oam_addr, 0);
      chk("reset count", o_sprite_count, 0);
      chk("reset overflow", o_overflow, 0);
      chk("reset sprite0", o_sprite0_hit, 0);
      i_reset_n = 1'b1;
      @(posedge i_clk);

      // 1: reset during the clear phase.
      snap = wr_count;
      start_pass(100, 0);
      run_cycles(5);
      #1 i_reset_n = 1'b0;
      #1;
      chk("t1 busy", o_busy, 0);
      chk("t1 sec_we", o_sec_we, 0);
      chk("t1 count", o_sprite_count, 0);
      chk("t1 writes before reset", wr_count - snap, 5);
      snap = wr_count;
      repeat (3) @(posedge i_clk);
      i_reset_n = 1'b1;
      repeat (4) @(posedge i_clk);
      chk("t1 writes after reset", wr_count - snap, 0);
      chk("t1 still idle", o_busy, 0);

      // 2: nothing in range.
      snap = wr_count;
      run_full("t2", 100, 0);
      chk("t2 done cycle", done_at, 160);
      chk("t2 write total", wr_count - snap, 32);
      chk("t2 count lit", o_sprite_count, 0);

      // 3: entries 0 and 5 at Y=96, 8x8, line 100.
      oam[0] = 8'd96; oam[1] = 8'h11; oam[2] = 8'h22; oam[3] = 8'h33;
      oam[20] = 8'd96; oam[21] = 8'h44; oam[22] = 8'h55; oam[23] = 8'h66;
      run_full("t3", 100, 0);
      chk("t3 done cycle", done_at, 172);
      chk("t3 count lit", o_sprite_count, 2);
      chk("t3 sprite0 lit", o_sprite0_hit, 1);
      chk("t3 slot0 b0", sec_mirror[0], 8'd96);
      chk("t3 slot0 b3", sec_mirror[3], 8'h33);
      chk("t3 slot1 b0", sec_mirror[4], 8'd96);
      chk("t3 slot1 b2", sec_mirror[6], 8'h55);
      chk("t3 slot2 b0", sec_mirror[8], 8'hFF);

      // 4: ten sprites at Y=50, overflow at line 57, none at line 58.
      oam_blank();
      for (int n = 0; n < 10; n++) begin
         oam[4*n] = 8'd50; oam[4*n+1] = 8'(n); oam[4*n+2] = 8'(n + 16); oam[4*n+3] = 8'(n + 32);
      end
      run_full("t4a", 57, 0);
      chk("t4a count lit", o_sprite_count, 8);
      chk("t4a overflow lit", o_overflow, 1);
      chk("t4a slot7 b1", sec_mirror[29], 8'd7);
      run_full("t4b", 58, 0);
      chk("t4b count lit", o_sprite_count, 0);
      chk("t4b overflow lit", o_overflow, 0);

      // 5: 8x16 range edge.
      oam_blank();
      oam[12] = 8'd90; oam[13] = 8'hA1; oam[14] = 8'hA2; oam[15] = 8'hA3;
      run_full("t5a", 105, 1);
      chk("t5a count lit", o_sprite_count, 1);
      chk("t5a sprite0 lit", o_sprite0_hit, 0);
      run_full("t5b", 106, 1);
      chk("t5b count lit", o_sprite_count, 0);
      run_full("t5c", 105, 0);
      chk("t5c count lit", o_sprite_count, 0);

      // 6: restart while pass A sits in its first byte fetch.
      oam_blank();
      oam[0]  = 8'd96;  oam[1]  = 8'h01; oam[2]  = 8'h02; oam[3]  = 8'h03;
      oam[40] = 8'd195; oam[41] = 8'hB1; oam[42] = 8'hB2; oam[43] = 8'hB3;
      done_seen = 0;
      start_pass(100, 0);
      run_cycles(34);
      check_cycle(34);
      chk("t6 abort in fetch_b addr", o_oam_addr, 1);
      start_pass(200, 0);
      run_cycles(exp_q.size());
      finish_check("t6");
      chk("t6 done pulses", done_seen, 1);
      chk("t6 count lit", o_sprite_count, 1);
      chk("t6 sprite0 lit", o_sprite0_hit, 0);
      chk("t6 slot0 b3", sec_mirror[3], 8'hB3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
